// File: rtl/dino_ctrl_pkg.sv
// Shared definitions for the Jump-Duck-Dino key scheduler: key FSM states,
// LEDG bit positions and default timing constants (50 MHz clock).
package dino_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    JUMP     = 2'd1,
    DUCK     = 2'd2,
    COOLDOWN = 2'd3
  } dino_state_e;

  // LEDG status bit positions
  localparam int LEDG_SPACEBAR = 0;
  localparam int LEDG_DOWNKEY  = 1;
  localparam int LEDG_COOLDOWN = 2;
  localparam int LEDG_PENDING  = 3;
  localparam int LEDG_JCNT_LSB = 4;
  localparam int LEDG_JCNT_MSB = 7;

  // Default timing: 10 ms debounce, 100 ms press, 50 ms cooldown at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_PRESS_CYCLES    = 5000000;
  localparam int DEF_COOLDOWN_CYCLES = 2500000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ldr_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one LDR sensor.
// The debounced level flips only after the synchronised input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles; any agreement clears the count.
module ldr_debounce
  import dino_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sensor_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser for the asynchronous sensor pin
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce decision: count disagreement, flip once the count reaches the limit
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= LIMIT) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/dino_key_scheduler.sv
// Jump/duck key scheduler: debounces both LDR sensors, arbitrates a single
// active key, enforces the jump press width and the release cooldown, and
// holds one queued jump. Optional macro JUMP_COUNTER_EN adds a 4-bit count of
// JUMP entries on LEDG[7:4]; without it LEDG[7:4] is tied low.
//
// Key timing: the press/cooldown counter holds the number of cycles spent in
// the current state, loaded with 1 on every state change. When the cooldown
// expires the IDLE arbitration is applied in the same step, so a queued or
// waiting request starts right after exactly COOLDOWN_CYCLES released cycles.
module dino_key_scheduler
  import dino_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PRESS_CYCLES    = DEF_PRESS_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       GPILDR1,
  input  logic       GPILDR2,
  output logic       SPACEBAR,
  output logic       DOWNKEY,
  output logic [7:0] LEDG
);

  localparam int CNT_MAX = max_int(PRESS_CYCLES, COOLDOWN_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PRESS_LIM = CW'(PRESS_CYCLES);
  localparam logic [CW-1:0] COOL_LIM  = CW'(COOLDOWN_CYCLES);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

  logic          jump_lvl, duck_lvl;
  logic          jump_lvl_q;
  logic          jump_req;
  dino_state_e   state_q, state_d;
  dino_state_e   arb_state;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          spacebar_q, downkey_q, cool_q;

  ldr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump_db (
    .clk_i    (CLOCK_50),
    .rst_ni   (RESET_N),
    .sensor_i (GPILDR1),
    .level_o  (jump_lvl)
  );

  ldr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_duck_db (
    .clk_i    (CLOCK_50),
    .rst_ni   (RESET_N),
    .sensor_i (GPILDR2),
    .level_o  (duck_lvl)
  );

  // Previous debounced jump level for rising-edge detection
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) jump_lvl_q <= 1'b0;
    else          jump_lvl_q <= jump_lvl;
  end

  assign jump_req = jump_lvl & ~jump_lvl_q;

  // IDLE arbitration: a jump (fresh or queued) beats duck
  always_comb begin
    arb_state = IDLE;
    if (jump_req || pending_q) arb_state = JUMP;
    else if (duck_lvl)         arb_state = DUCK;
  end

  // Next-state and pending-flag logic
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        state_d = arb_state;
        if (arb_state == JUMP) pending_d = 1'b0;
      end
      JUMP: begin
        if (jump_req)           pending_d = 1'b1;
        if (cnt_q >= PRESS_LIM) state_d   = COOLDOWN;
      end
      DUCK: begin
        if (jump_req) begin
          pending_d = 1'b1;
          if (cnt_q >= PRESS_LIM) state_d = COOLDOWN;
        end else if ((cnt_q >= PRESS_LIM) && !duck_lvl) begin
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (jump_req) pending_d = 1'b1;
        if (cnt_q >= COOL_LIM) begin
          state_d = arb_state;
          if (arb_state == JUMP) pending_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // Cycles-in-state counter: 1 on entry, saturating afterwards
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = CW'(1);
    else if (cnt_q < CNT_SAT) cnt_d = cnt_q + CW'(1);
  end

  // FSM, counter, pending flag and registered key outputs
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      spacebar_q <= 1'b0;
      downkey_q  <= 1'b0;
      cool_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      spacebar_q <= (state_d == JUMP);
      downkey_q  <= (state_d == DUCK);
      cool_q     <= (state_d == COOLDOWN);
    end
  end

  assign SPACEBAR = spacebar_q;
  assign DOWNKEY  = downkey_q;

  assign LEDG[LEDG_SPACEBAR] = spacebar_q;
  assign LEDG[LEDG_DOWNKEY]  = downkey_q;
  assign LEDG[LEDG_COOLDOWN] = cool_q;
  assign LEDG[LEDG_PENDING]  = pending_q;

`ifdef JUMP_COUNTER_EN
  logic [3:0] jcnt_q;

  // Count entries into JUMP, wrapping 15 -> 0
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) jcnt_q <= 4'd0;
    else if ((state_d == JUMP) && (state_q != JUMP)) jcnt_q <= jcnt_q + 4'd1;
  end

  assign LEDG[LEDG_JCNT_MSB:LEDG_JCNT_LSB] = jcnt_q;
`else
  assign LEDG[LEDG_JCNT_MSB:LEDG_JCNT_LSB] = 4'd0;
`endif

endmodule

// File: tb/tb_dino_key_scheduler.sv
// Directed bench for dino_key_scheduler with DEBOUNCE=4, PRESS=8, COOLDOWN=4.
// Step t of a scenario drives the sensors sampled at relative edge t and
// records the outputs one time unit after that edge into the history arrays.
module tb_dino_key_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gpi1 = 1'b0;
  logic       gpi2 = 1'b0;
  logic       spacebar, downkey;
  logic [7:0] ledg;

  int n_checks = 0;
  int n_fail   = 0;

  logic       sb_h  [0:63];
  logic       dk_h  [0:63];
  logic [7:0] led_h [0:63];

  dino_key_scheduler #(
    .DEBOUNCE_CYCLES (4),
    .PRESS_CYCLES    (8),
    .COOLDOWN_CYCLES (4)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .GPILDR1  (gpi1),
    .GPILDR2  (gpi2),
    .SPACEBAR (spacebar),
    .DOWNKEY  (downkey),
    .LEDG     (ledg)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Driver: apply sensors for one edge, record outputs just after it
  task automatic drive_cycle(input logic j, input logic d, input int t);
    gpi1 = j;
    gpi2 = d;
    @(posedge clk);
    #1;
    sb_h[t]  = spacebar;
    dk_h[t]  = downkey;
    led_h[t] = ledg;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (spacebar !== 1'b0) begin n_fail++; $display("FAIL reset_spacebar: got %b want 0", spacebar); end
    n_checks++;
    if (downkey !== 1'b0) begin n_fail++; $display("FAIL reset_downkey: got %b want 0", downkey); end
    n_checks++;
    if (ledg !== 8'h00) begin n_fail++; $display("FAIL reset_ledg: got %h want 00", ledg); end
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) drive_cycle(1'b0, 1'b0, t);
    for (int t = 0; t < 10; t++) begin
      n_checks++;
      if (led_h[t] !== 8'h00) begin n_fail++; $display("FAIL idle_ledg t=%0d: got %h want 00", t, led_h[t]); end
    end
  endtask

  task automatic test_jump();
    logic [3:0] exp_led;
    for (int t = 0; t < 40; t++) drive_cycle(t < 20, 1'b0, t);
    for (int t = 0; t < 40; t++) begin
      exp_led = {1'b0, (t >= 15 && t <= 18), 1'b0, (t >= 7 && t <= 14)};
      n_checks++;
      if (sb_h[t] !== exp_led[0]) begin n_fail++; $display("FAIL jump_sb t=%0d: got %b want %b", t, sb_h[t], exp_led[0]); end
      n_checks++;
      if (dk_h[t] !== 1'b0) begin n_fail++; $display("FAIL jump_dk t=%0d: got %b want 0", t, dk_h[t]); end
      n_checks++;
      if (led_h[t][3:0] !== exp_led) begin n_fail++; $display("FAIL jump_led t=%0d: got %h want %h", t, led_h[t][3:0], exp_led); end
    end
  endtask

  task automatic test_glitch();
    for (int t = 0; t < 20; t++) drive_cycle(t < 3, 1'b0, t);
    for (int t = 0; t < 20; t++) begin
      n_checks++;
      if ({sb_h[t], dk_h[t], led_h[t][3:0]} !== 6'b0) begin
        n_fail++;
        $display("FAIL glitch t=%0d: got sb=%b dk=%b led=%h want all 0", t, sb_h[t], dk_h[t], led_h[t][3:0]);
      end
    end
  endtask

  task automatic test_duck();
    logic [3:0] exp_led;
    for (int t = 0; t < 60; t++) drive_cycle(1'b0, t < 30, t);
    for (int t = 0; t < 60; t++) begin
      exp_led = {1'b0, (t >= 37 && t <= 40), (t >= 7 && t <= 36), 1'b0};
      n_checks++;
      if (dk_h[t] !== exp_led[1]) begin n_fail++; $display("FAIL duck_dk t=%0d: got %b want %b", t, dk_h[t], exp_led[1]); end
      n_checks++;
      if (sb_h[t] !== 1'b0) begin n_fail++; $display("FAIL duck_sb t=%0d: got %b want 0", t, sb_h[t]); end
      n_checks++;
      if (led_h[t][3:0] !== exp_led) begin n_fail++; $display("FAIL duck_led t=%0d: got %h want %h", t, led_h[t][3:0], exp_led); end
    end
  endtask

  task automatic test_jump_priority();
    logic [3:0] exp_led;
    for (int t = 0; t < 60; t++) drive_cycle(t < 20, t < 40, t);
    for (int t = 0; t < 60; t++) begin
      exp_led = {1'b0, (t >= 15 && t <= 18) || (t >= 47 && t <= 50),
                 (t >= 19 && t <= 46), (t >= 7 && t <= 14)};
      n_checks++;
      if ({dk_h[t], sb_h[t]} !== exp_led[1:0]) begin
        n_fail++;
        $display("FAIL prio_keys t=%0d: got dk=%b sb=%b want dk=%b sb=%b", t, dk_h[t], sb_h[t], exp_led[1], exp_led[0]);
      end
      n_checks++;
      if ((sb_h[t] & dk_h[t]) !== 1'b0) begin n_fail++; $display("FAIL prio_overlap t=%0d: got both keys 1 want at most one", t); end
      n_checks++;
      if (led_h[t][3:0] !== exp_led) begin n_fail++; $display("FAIL prio_led t=%0d: got %h want %h", t, led_h[t][3:0], exp_led); end
    end
  endtask

  // Second debounced jump lands in cooldown and replays after exactly 4 low cycles
  task automatic test_back_to_back();
    logic [3:0] exp_led;
    for (int t = 0; t < 40; t++) drive_cycle((t < 5) || (t >= 10 && t < 20), 1'b0, t);
    for (int t = 0; t < 40; t++) begin
      exp_led = {(t >= 17 && t <= 18), (t >= 15 && t <= 18) || (t >= 27 && t <= 30),
                 1'b0, (t >= 7 && t <= 14) || (t >= 19 && t <= 26)};
      n_checks++;
      if (sb_h[t] !== exp_led[0]) begin n_fail++; $display("FAIL b2b_sb t=%0d: got %b want %b", t, sb_h[t], exp_led[0]); end
      n_checks++;
      if (led_h[t][3:0] !== exp_led) begin n_fail++; $display("FAIL b2b_led t=%0d: got %h want %h", t, led_h[t][3:0], exp_led); end
    end
  endtask

  // Jump queued during early duck; a later jump ends the duck but yields one pulse only
  task automatic test_pending_one_deep();
    logic [3:0] exp_led;
    for (int t = 0; t < 60; t++) drive_cycle((t >= 2 && t < 7) || (t >= 12 && t < 17), t < 40, t);
    for (int t = 0; t < 60; t++) begin
      exp_led = {(t >= 9 && t <= 22),
                 (t >= 19 && t <= 22) || (t >= 31 && t <= 34) || (t >= 47 && t <= 50),
                 (t >= 7 && t <= 18) || (t >= 35 && t <= 46),
                 (t >= 23 && t <= 30)};
      n_checks++;
      if ({dk_h[t], sb_h[t]} !== exp_led[1:0]) begin
        n_fail++;
        $display("FAIL pend_keys t=%0d: got dk=%b sb=%b want dk=%b sb=%b", t, dk_h[t], sb_h[t], exp_led[1], exp_led[0]);
      end
      n_checks++;
      if (led_h[t][3:0] !== exp_led) begin n_fail++; $display("FAIL pend_led t=%0d: got %h want %h", t, led_h[t][3:0], exp_led); end
    end
  endtask

  task automatic test_reset_mid_press();
    // Part A: reset while SPACEBAR is high
    for (int t = 0; t <= 10; t++) drive_cycle(1'b1, 1'b0, t);
    n_checks++;
    if (spacebar !== 1'b1) begin n_fail++; $display("FAIL rst_pre_sb: got %b want 1", spacebar); end
    rst_n = 1'b0;
    gpi1  = 1'b0;
    #1;
    n_checks++;
    if (spacebar !== 1'b0) begin n_fail++; $display("FAIL rst_async_sb: got %b want 0", spacebar); end
    n_checks++;
    if (ledg !== 8'h00) begin n_fail++; $display("FAIL rst_async_ledg: got %h want 00", ledg); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 30; t++) drive_cycle(1'b0, 1'b0, t);
    for (int t = 0; t < 30; t++) begin
      n_checks++;
      if ({sb_h[t], dk_h[t]} !== 2'b00) begin n_fail++; $display("FAIL rst_a_after t=%0d: got sb=%b dk=%b want 0 0", t, sb_h[t], dk_h[t]); end
    end
    // Part B: reset while a jump is pending in cooldown
    for (int t = 0; t <= 17; t++) drive_cycle((t < 5) || (t >= 10), 1'b0, t);
    n_checks++;
    if (ledg[3] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_pending: got %b want 1", ledg[3]); end
    rst_n = 1'b0;
    gpi1  = 1'b0;
    #1;
    n_checks++;
    if (ledg !== 8'h00) begin n_fail++; $display("FAIL rst_pend_ledg: got %h want 00", ledg); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 30; t++) drive_cycle(1'b0, 1'b0, t);
    for (int t = 0; t < 30; t++) begin
      n_checks++;
      if ({sb_h[t], led_h[t][3]} !== 2'b00) begin n_fail++; $display("FAIL rst_b_replay t=%0d: got sb=%b pend=%b want 0 0", t, sb_h[t], led_h[t][3]); end
    end
  endtask

  task automatic test_jump_counter();
    logic [3:0] exp_cnt;
    n_checks++;
    if (ledg[7:4] !== 4'd0) begin n_fail++; $display("FAIL jcnt_start: got %0d want 0", ledg[7:4]); end
    for (int n = 0; n < 17; n++) begin
      for (int t = 0; t < 20; t++) drive_cycle(t < 5, 1'b0, t);
      if (n == 0 || n == 14 || n == 15 || n == 16) begin
`ifdef JUMP_COUNTER_EN
        exp_cnt = 4'(n + 1);
`else
        exp_cnt = 4'd0;
`endif
        n_checks++;
        if (ledg[7:4] !== exp_cnt) begin n_fail++; $display("FAIL jcnt after %0d jumps: got %0d want %0d", n + 1, ledg[7:4], exp_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_glitch();
    test_duck();
    test_jump_priority();
    test_back_to_back();
    test_pending_one_deep();
    test_reset_mid_press();
    test_jump_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
